// File: rtl/dcache_tag_cmp.sv
// ============================================================================
// Module   : dcache_tag_cmp
// Purpose  : Fixed-priority SRAM port arbiter with next-cycle tag compare.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dcache_pkg;
    localparam int DCACHE_TAG_WIDTH  = 44;
    localparam int DCACHE_LINE_WIDTH = 128;
    localparam int DCACHE_WAYS       = 8;

    typedef struct packed {
        logic [DCACHE_TAG_WIDTH-1:0]  tag;
        logic [DCACHE_LINE_WIDTH-1:0] data;
        logic                         valid;
        logic                         dirty;
    } cache_line_t;

    typedef struct packed {
        logic [DCACHE_TAG_WIDTH-1:0]    tag;
        logic [DCACHE_LINE_WIDTH/8-1:0] data;
        logic [DCACHE_WAYS-1:0]         vldrty;
    } cl_be_t;
endpackage

module dcache_tag_cmp
    import dcache_pkg::*;
#(
    parameter int NR_PORTS         = 3,
    parameter int ADDR_WIDTH       = 64,
    parameter int DCACHE_SET_ASSOC = 8
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic [NR_PORTS-1:0][DCACHE_SET_ASSOC-1:0]  req_i,
    output logic [NR_PORTS-1:0]                        gnt_o,
    input  logic [NR_PORTS-1:0][ADDR_WIDTH-1:0]        addr_i,
    input  cache_line_t [NR_PORTS-1:0]                 wdata_i,
    input  logic [NR_PORTS-1:0]                        we_i,
    input  cl_be_t [NR_PORTS-1:0]                      be_i,
    input  logic [NR_PORTS-1:0][DCACHE_TAG_WIDTH-1:0]  tag_i,
    output cache_line_t [DCACHE_SET_ASSOC-1:0]         rdata_o,
    output logic [DCACHE_SET_ASSOC-1:0]                hit_way_o,
    output logic [DCACHE_SET_ASSOC-1:0]                req_o,
    output logic [ADDR_WIDTH-1:0]                      addr_o,
    output cache_line_t                                wdata_o,
    output logic                                       we_o,
    output cl_be_t                                     be_o,
    input  cache_line_t [DCACHE_SET_ASSOC-1:0]         rdata_i
);

    localparam int ID_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

    logic [ID_W-1:0]             id_d, id_q;
    logic                        found;
    logic [DCACHE_TAG_WIDTH-1:0] sel_tag;

    // Lowest-index active port wins; an idle cycle leaves everything at zero.
    always_comb begin
        found  = 1'b0;
        id_d   = '0;
        gnt_o  = '0;
        req_o  = '0;
        addr_o = '0;
        wdata_o = '0;
        we_o   = 1'b0;
        be_o   = '0;
        for (int i = 0; i < NR_PORTS; i++) begin
            if (!found && (|req_i[i])) begin
                found    = 1'b1;
                id_d     = ID_W'(i);
                gnt_o[i] = 1'b1;
                req_o    = req_i[i];
                addr_o   = addr_i[i];
                wdata_o  = wdata_i[i];
                we_o     = we_i[i];
                be_o     = be_i[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_q <= '0;
        end else begin
            id_q <= id_d;
        end
    end

    // The tag arrives one cycle after the grant, alongside the SRAM read data.
    always_comb begin
        sel_tag = '0;
        for (int i = 0; i < NR_PORTS; i++) begin
            if (id_q == ID_W'(i)) begin
                sel_tag = tag_i[i];
            end
        end
    end

    generate
        for (genvar w = 0; w < DCACHE_SET_ASSOC; w++) begin : g_hit
            assign hit_way_o[w] = rdata_i[w].valid && (rdata_i[w].tag == sel_tag);
        end
    endgenerate

    assign rdata_o = rdata_i;

endmodule

`default_nettype wire

// File: tb/tb_dcache_tag_cmp.sv
// ============================================================================
// Module   : tb_dcache_tag_cmp
// Purpose  : Self-checking bench for dcache_tag_cmp.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dcache_tag_cmp;
    import dcache_pkg::*;

    localparam int NR = 3;
    localparam int AW = 64;
    localparam int SA = 8;
    localparam int TW = DCACHE_TAG_WIDTH;

    logic                       clk;
    logic                       rst_n;
    logic [NR-1:0][SA-1:0]      req;
    logic [NR-1:0]              gnt;
    logic [NR-1:0][AW-1:0]      addr;
    cache_line_t [NR-1:0]       wdata;
    logic [NR-1:0]              we;
    cl_be_t [NR-1:0]            be;
    logic [NR-1:0][TW-1:0]      tag;
    cache_line_t [SA-1:0]       rdata_out;
    logic [SA-1:0]              hit;
    logic [SA-1:0]              req_out;
    logic [AW-1:0]              addr_out;
    cache_line_t                wdata_out;
    logic                       we_out;
    cl_be_t                     be_out;
    cache_line_t [SA-1:0]       rdata_in;

    int n_chk  = 0;
    int n_fail = 0;

    dcache_tag_cmp #(.NR_PORTS(NR), .ADDR_WIDTH(AW), .DCACHE_SET_ASSOC(SA)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req),
        .gnt_o     (gnt),
        .addr_i    (addr),
        .wdata_i   (wdata),
        .we_i      (we),
        .be_i      (be),
        .tag_i     (tag),
        .rdata_o   (rdata_out),
        .hit_way_o (hit),
        .req_o     (req_out),
        .addr_o    (addr_out),
        .wdata_o   (wdata_out),
        .we_o      (we_out),
        .be_o      (be_out),
        .rdata_i   (rdata_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int winner(input logic [NR-1:0][SA-1:0] r);
        for (int i = 0; i < NR; i++) begin
            if (r[i] != '0) return i;
        end
        return -1;
    endfunction

    function automatic cache_line_t mk(input logic [TW-1:0] t, input logic v);
        cache_line_t c;
        c       = '0;
        c.tag   = t;
        c.valid = v;
        return c;
    endfunction

    // Reference model: which port owns the compare this cycle.
    int m_id = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_id = 0;
        else        m_id = (winner(req) < 0) ? 0 : winner(req);
    end

    int          cw;
    logic [SA-1:0] eh;
    always @(negedge clk) begin
        cw = winner(req);
        chk("gnt", 256'(gnt), (cw < 0) ? 256'(0) : (256'(1) << cw));
        if (cw >= 0) begin
            chk("req_o",   256'(req_out),   256'(req[cw]));
            chk("addr_o",  256'(addr_out),  256'(addr[cw]));
            chk("wdata_o", 256'(wdata_out), 256'(wdata[cw]));
            chk("we_o",    256'(we_out),    256'(we[cw]));
            chk("be_o",    256'(be_out),    256'(be[cw]));
        end else begin
            chk("idle_outs", 256'({req_out, addr_out, wdata_out, we_out, be_out}), 256'(0));
        end
        for (int k = 0; k < SA; k++) begin
            eh[k] = rdata_in[k].valid && (rdata_in[k].tag == tag[m_id]);
            chk("rdata_o", 256'(rdata_out[k]), 256'(rdata_in[k]));
        end
        chk("hit_way", 256'(hit), 256'(eh));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        req   = '0;
        addr  = '0;
        wdata = '0;
        we    = '0;
        be    = '0;
    endtask

    cache_line_t lw;
    cl_be_t      lb;
    int          seq   [5] = '{2, 1, 0, 2, 1};
    int          wayof [3] = '{1, 2, 6};

    initial begin
        rst_n    = 1'b0;
        clear();
        tag      = '0;
        rdata_in = '0;
        repeat (2) cyc();
        #3;
        chk("rst_gnt",  256'(gnt),        256'(0));
        chk("rst_id",   256'(dut.id_q),   256'(0));
        chk("rst_hit",  256'(hit),        256'(0));
        cyc();
        rst_n = 1'b1;

        // Ports 1 and 2 collide: port 1 wins.
        cyc(); clear();
        req[1] = 8'h01; req[2] = 8'h02; addr[1] = 64'h40; addr[2] = 64'h80;
        #3;
        chk("prio_gnt",  256'(gnt),      256'(3'b010));
        chk("prio_addr", 256'(addr_out), 256'(64'h40));
        chk("prio_req",  256'(req_out),  256'(8'h01));

        // Full-way write from port 0.
        cyc(); clear();
        lw = '0; lw.tag = 44'h123; lw.data = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;
        lw.valid = 1'b1; lw.dirty = 1'b1;
        lb = '0; lb.data = 16'hF0F0; lb.vldrty = 8'h81;
        req[0] = 8'hFF; we[0] = 1'b1; wdata[0] = lw; be[0] = lb;
        #3;
        chk("wr_req",   256'(req_out),   256'(8'hFF));
        chk("wr_we",    256'(we_out),    256'(1));
        chk("wr_wdata", 256'(wdata_out), 256'(lw));
        chk("wr_be",    256'(be_out),    256'(lb));

        // Port 2 granted, hit on way 3 next cycle.
        cyc(); clear();
        req[2] = 8'h10; tag[2] = 44'hABC; tag[0] = 44'h111;
        #3;
        chk("p2_gnt", 256'(gnt), 256'(3'b100));
        cyc(); clear();
        for (int k = 0; k < SA; k++) rdata_in[k] = mk(44'hF00 + TW'(k), 1'b1);
        rdata_in[0] = mk(44'h111, 1'b1);
        rdata_in[3] = mk(44'hABC, 1'b1);
        #3;
        chk("hit_way3", 256'(hit), 256'(8'b0000_1000));

        // Same, but way 3 invalid.
        cyc(); clear();
        req[2] = 8'h10;
        cyc(); clear();
        rdata_in[3] = mk(44'hABC, 1'b0);
        #3;
        chk("hit_inv", 256'(hit), 256'(8'h00));

        // Idle after port-2 grant: compare falls back to port 0's tag.
        cyc(); clear();
        req[2] = 8'h01;
        cyc(); clear();
        #3;
        chk("idle_gnt", 256'(gnt),     256'(0));
        chk("idle_req", 256'(req_out), 256'(0));
        cyc(); clear();
        tag[0] = 44'h5A5; tag[2] = 44'hB0B;
        rdata_in = '0;
        rdata_in[1] = mk(44'h5A5, 1'b1);
        rdata_in[5] = mk(44'hB0B, 1'b1);
        #3;
        chk("idle_hit", 256'(hit), 256'(8'b0000_0010));

        // Asynchronous reset right after a port-1 grant.
        cyc(); clear();
        req[1] = 8'h01; tag[1] = 44'hC0C;
        cyc(); clear();
        chk("pre_rst_id", 256'(dut.id_q), 256'(1));
        rst_n = 1'b0;
        #1;
        chk("async_id", 256'(dut.id_q), 256'(0));
        req[2] = 8'h04;
        rdata_in = '0;
        rdata_in[2] = mk(44'h5A5, 1'b1);
        rdata_in[4] = mk(44'hC0C, 1'b1);
        #1;
        chk("rst_hit_t0", 256'(hit),     256'(8'b0000_0100));
        chk("rst_gnt_fw", 256'(gnt),     256'(3'b100));
        chk("rst_req_fw", 256'(req_out), 256'(8'h04));
        cyc(); clear();
        rst_n = 1'b1;

        // Back-to-back grants to different ports.
        tag[0] = 44'h101; tag[1] = 44'h102; tag[2] = 44'h106;
        for (int k = 0; k < SA; k++) rdata_in[k] = mk(44'h100 + TW'(k), 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc(); clear();
            req[seq[i]] = 8'h01 << i;
            addr[seq[i]] = 64'h1000 + 64'(i);
            #3;
            chk("b2b_gnt", 256'(gnt), 256'(1) << seq[i]);
            if (i > 0) chk("b2b_hit", 256'(hit), 256'(1) << wayof[seq[i-1]]);
        end
        cyc(); clear();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dcache_tag_cmp.md
DCACHE_TAG_CMP -- requirements
Module: dcache_tag_cmp

Interface
REQ-001 SHALL have parameter NR_PORTS, default 3; number of requesting masters (index 0 = highest priority).
REQ-002 SHALL have parameter ADDR_WIDTH, default 64; width of the forwarded SRAM index address.
REQ-003 SHALL have parameter DCACHE_SET_ASSOC, default 8; number of ways.
REQ-004 SHALL use the codebase types `cache_line_t` (fields tag, data, valid, dirty) and `cl_be_t` (fields tag, data, vldrty byte enables) and the tag width `DCACHE_TAG_WIDTH`.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 clk_i  input  1  clock.
REQ-007 rst_ni  input  1  asynchronous active-low reset.
REQ-008 req_i  input  [NR_PORTS][DCACHE_SET_ASSOC]  per-port way-select request; a port requests when any bit is set.
REQ-009 gnt_o  output  [NR_PORTS]  grant, combinational, same cycle as the request.
REQ-010 addr_i  input  [NR_PORTS][ADDR_WIDTH]  per-port index address.
REQ-011 wdata_i  input  cache_line_t[NR_PORTS]  per-port write line.
REQ-012 we_i  input  [NR_PORTS]  per-port write enable.
REQ-013 be_i  input  cl_be_t[NR_PORTS]  per-port byte enables.
REQ-014 tag_i  input  [NR_PORTS][DCACHE_TAG_WIDTH]  per-port compare tag, valid the cycle after the grant.
REQ-015 rdata_o  output  cache_line_t[DCACHE_SET_ASSOC]  read lines returned to the masters.
REQ-016 hit_way_o  output  [DCACHE_SET_ASSOC]  per-way hit vector.
REQ-017 req_o  output  [DCACHE_SET_ASSOC]  way enables to the SRAM.
REQ-018 addr_o  output  [ADDR_WIDTH]  SRAM address.
REQ-019 wdata_o  output  cache_line_t  SRAM write data.
REQ-020 we_o  output  1  SRAM write enable.
REQ-021 be_o  output  cl_be_t  SRAM byte enables.
REQ-022 rdata_i  input  cache_line_t[DCACHE_SET_ASSOC]  SRAM read data, 1-cycle latency.

Function
REQ-023 The arbiter SHALL use fixed priority, where the lowest-index port with a nonzero req_i wins.
REQ-024 The winning port SHALL get gnt_o[winner]=1, and all other grant bits SHALL be 0; if no port requests, gnt_o SHALL be 0.
REQ-025 req_o, addr_o, wdata_o, we_o and be_o SHALL equal the winner's req_i, addr_i, wdata_i, we_i and be_i, combinationally in the same cycle.
REQ-026 With no requester, req_o, addr_o, wdata_o, we_o and be_o SHALL all be 0.
REQ-027 A register id_q SHALL capture the winner index every clock edge; with no requester it SHALL capture 0.
REQ-028 The selected tag SHALL be sel_tag = tag_i[id_q], i.e. the tag of the port granted in the previous cycle.
REQ-029 hit_way_o[w] SHALL be 1 iff rdata_i[w].valid and rdata_i[w].tag == sel_tag; the logic is purely combinational.
REQ-030 If several ways match, all matching bits SHALL be set; resolving multiple hits is the masters' responsibility.
REQ-031 rdata_o SHALL be a pass-through of rdata_i.
REQ-032 Writes SHALL require no special handling beyond forwarding, and the grant SHALL NOT depend on we_i.
REQ-033 Back-to-back grants to different ports SHALL be allowed every cycle, and id_q SHALL track each one.

Reset
REQ-034 While rst_ni is low, id_q SHALL be 0.
REQ-035 The combinational outputs SHALL follow the inputs during reset.
REQ-036 A reset asserted mid-operation SHALL force id_q to 0 immediately, so the next hit compare uses tag_i[0].

Verification
REQ-037 Requests on ports 1 and 2 in the same cycle, addr 0x40/0x80 -> gnt_o=3'b010, addr_o=0x40.
REQ-038 Port 0 requests with req_i[0]=8'hFF, we_i=1 -> req_o=8'hFF, we_o=1, wdata_o=wdata_i[0], be_o=be_i[0].
REQ-039 Port 2 granted in cycle N, tag_i[2]=T, and in N+1 rdata_i[3]={tag T, valid 1} with all other ways mismatching -> hit_way_o=8'b0000_1000.
REQ-040 Same as REQ-039 but rdata_i[3].valid=0 -> hit_way_o=0.
REQ-041 Idle cycle after a grant to port 2 -> next-cycle compare uses tag_i[0], all req_o/gnt_o are 0.
REQ-042 Assert rst_ni low after a grant to port 1 -> id_q=0 immediately.
